// File: rtl/data_permuter_pipe_pkg.sv
// Shared types and helpers for the lane permuter family.
package data_swapper_pkg;

    typedef enum logic [1:0] {
        PERM_PASS = 2'd0,
        PERM_SWAP = 2'd1,
        PERM_ROT  = 2'd2,
        PERM_REV  = 2'd3
    } perm_mode_e;

    // Source lane for output lane `lane` under a rotate of `rot` (rot taken mod num_ch).
    function automatic int lane_rot_idx(input int lane, input int rot, input int num_ch);
        return (lane + (rot % num_ch)) % num_ch;
    endfunction

endpackage

// File: rtl/data_permuter_pipe_if.sv
// Valid/ready bus carrying packed lanes plus per-beat permutation controls.
interface data_permuter_pipe_if #(
    parameter int WIDTH  = 8,
    parameter int NUM_CH = 4,
    parameter int ROT_W  = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
);
    logic                    in_valid;
    logic                    in_ready;
    logic [NUM_CH*WIDTH-1:0] in_data;
    logic [1:0]              in_mode;
    logic [ROT_W-1:0]        in_rot;
    logic                    out_valid;
    logic                    out_ready;
    logic [NUM_CH*WIDTH-1:0] out_data;

    modport slave (
        input  in_valid, in_data, in_mode, in_rot, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, in_mode, in_rot, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/data_permuter_pipe_core.sv
// Combinational lane mux: selects a source lane for every output lane from mode and rotate amount.
module data_permute_core
    import data_swapper_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NUM_CH = 4,
    parameter int ROT_W  = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH*WIDTH-1:0] data,
    input  perm_mode_e              mode,
    input  logic [ROT_W-1:0]        rot,
    output logic [NUM_CH*WIDTH-1:0] perm
);
    int src;

    always_comb begin
        perm = '0;
        src  = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            case (mode)
                // An unpaired last lane (odd NUM_CH) maps to itself.
                PERM_SWAP: src = (i % 2 == 0) ? ((i + 1 < NUM_CH) ? i + 1 : i) : i - 1;
                PERM_ROT:  src = lane_rot_idx(i, int'(rot), NUM_CH);
                PERM_REV:  src = NUM_CH - 1 - i;
                default:   src = i;
            endcase
            perm[i*WIDTH +: WIDTH] = data[src*WIDTH +: WIDTH];
        end
    end
endmodule

// File: rtl/data_permuter_pipe.sv
// Registered lane permuter: permutation captured at accept into an output register backed by one skid entry.
module data_permuter_pipe
    import data_swapper_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NUM_CH = 4,
    parameter int ROT_W  = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
    input logic               clk,
    input logic               rst_n,
    data_permuter_pipe_if.slave bus
);
    logic [NUM_CH*WIDTH-1:0] perm_p0;
    perm_mode_e              mode_p0;
    logic [NUM_CH*WIDTH-1:0] or_data_p1;
    logic [NUM_CH*WIDTH-1:0] sk_data_p1;
    logic                    or_vld_p1;
    logic                    sk_vld_p1;
    logic                    accept;
    logic                    drain;

    assign mode_p0 = perm_mode_e'(bus.in_mode);

    data_permute_core #(
        .WIDTH  (WIDTH),
        .NUM_CH (NUM_CH),
        .ROT_W  (ROT_W)
    ) u_core (
        .data (bus.in_data),
        .mode (mode_p0),
        .rot  (bus.in_rot),
        .perm (perm_p0)
    );

    // in_ready depends only on the skid flag, so out_ready never reaches it combinationally.
    assign bus.in_ready  = !sk_vld_p1;
    assign bus.out_valid = or_vld_p1;
    assign bus.out_data  = or_data_p1;

    assign accept = bus.in_valid && !sk_vld_p1;
    assign drain  = or_vld_p1 && bus.out_ready;

    // ---- stage p0 -> p1: output register and skid entry ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            or_vld_p1  <= 1'b0;
            sk_vld_p1  <= 1'b0;
            or_data_p1 <= '0;
            sk_data_p1 <= '0;
        end else if (drain && sk_vld_p1) begin
            // accept cannot coincide here because in_ready is low
            or_data_p1 <= sk_data_p1;
            sk_vld_p1  <= 1'b0;
        end else if (accept && (!or_vld_p1 || drain)) begin
            or_data_p1 <= perm_p0;
            or_vld_p1  <= 1'b1;
        end else if (accept) begin
            sk_data_p1 <= perm_p0;
            sk_vld_p1  <= 1'b1;
        end else if (drain) begin
            or_vld_p1  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_data_permuter_pipe.sv
// Self-checking bench for data_permuter_pipe (4-lane and 3-lane instances, 8-bit lanes).
module tb_data_permuter_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    data_permuter_pipe_if #(.WIDTH(8), .NUM_CH(4), .ROT_W(2)) if4 ();
    data_permuter_pipe_if #(.WIDTH(8), .NUM_CH(3), .ROT_W(2)) if3 ();

    data_permuter_pipe #(.WIDTH(8), .NUM_CH(4), .ROT_W(2)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if4.slave)
    );

    data_permuter_pipe #(.WIDTH(8), .NUM_CH(3), .ROT_W(2)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if3.slave)
    );

    // Reference permutation built directly from the lane rules on a byte array.
    function automatic logic [31:0] ref_perm(input logic [31:0] x, input int mode, input int rot, input int n);
        logic [7:0] lanes [4];
        logic [31:0] o;
        int j;
        for (int k = 0; k < 4; k++) lanes[k] = x[k*8 +: 8];
        o = '0;
        for (int i = 0; i < n; i++) begin
            if (mode == 1)      j = (i % 2 == 1) ? i - 1 : ((i + 1 < n) ? i + 1 : i);
            else if (mode == 2) j = (i + (rot % n)) % n;
            else if (mode == 3) j = n - 1 - i;
            else                j = i;
            o[i*8 +: 8] = lanes[j];
        end
        return o;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        if4.in_valid = 1'b1; if4.in_data = 32'hdeadbeef; if4.in_mode = 2'd0; if4.in_rot = '0;
        if4.out_ready = 1'b1;
        if3.in_valid = 1'b0; if3.in_data = '0; if3.in_mode = 2'd0; if3.in_rot = '0;
        if3.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (if4.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", if4.out_valid); end
        total++; if (if4.out_data !== 32'h0) begin bad++; $display("FAIL reset_out_data got=%h want=0", if4.out_data); end
        total++; if (if4.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", if4.in_ready); end
        rst_n = 1'b1;
        if4.in_valid = 1'b0;
        @(negedge clk);
        total++; if (if4.out_valid !== 1'b0) begin bad++; $display("FAIL reset_dropped_beat got=%b want=0", if4.out_valid); end
    endtask

    task automatic test_pass_idle();
        if4.in_valid = 1'b1; if4.in_data = 32'h44332211; if4.in_mode = 2'd0; if4.in_rot = '0;
        @(negedge clk);
        if4.in_valid = 1'b0;
        total++; if (if4.out_valid !== 1'b1) begin bad++; $display("FAIL pass_valid got=%b want=1", if4.out_valid); end
        total++; if (if4.out_data !== 32'h44332211) begin bad++; $display("FAIL pass_data got=%h want=44332211", if4.out_data); end
        @(negedge clk);
        total++; if (if4.out_valid !== 1'b0) begin bad++; $display("FAIL idle_valid got=%b want=0", if4.out_valid); end
        total++; if (if4.out_data !== 32'h44332211) begin bad++; $display("FAIL idle_data_hold got=%h want=44332211", if4.out_data); end
    endtask

    task automatic test_modes();
        logic [1:0]  modes [6] = '{2'd1, 2'd3, 2'd2, 2'd2, 2'd2, 2'd2};
        logic [1:0]  rots  [6] = '{2'd0, 2'd0, 2'd1, 2'd3, 2'd0, 2'd2};
        logic [31:0] exps  [6] = '{32'h33441122, 32'h11223344, 32'h11443322,
                                   32'h33221144, 32'h44332211, 32'h22114433};
        for (int t = 0; t < 6; t++) begin
            if4.in_valid = 1'b1; if4.in_data = 32'h44332211;
            if4.in_mode = modes[t]; if4.in_rot = rots[t];
            @(negedge clk);
            if4.in_valid = 1'b0;
            if4.in_mode = 2'd0; if4.in_rot = '0;
            total++; if (if4.out_valid !== 1'b1) begin bad++; $display("FAIL mode%0d_valid case=%0d got=%b want=1", modes[t], t, if4.out_valid); end
            total++; if (if4.out_data !== exps[t]) begin bad++; $display("FAIL mode%0d_data case=%0d got=%h want=%h", modes[t], t, if4.out_data, exps[t]); end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        if4.out_ready = 1'b0;
        if4.in_valid = 1'b1; if4.in_data = 32'h44332211; if4.in_mode = 2'd0;
        @(negedge clk);
        total++; if (if4.in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_after_a got=%b want=1", if4.in_ready); end
        if4.in_data = 32'h44332211; if4.in_mode = 2'd3;
        @(negedge clk);
        if4.in_valid = 1'b0; if4.in_mode = 2'd0;
        total++; if (if4.in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_after_b got=%b want=0", if4.in_ready); end
        total++; if (if4.out_data !== 32'h44332211) begin bad++; $display("FAIL bp_hold_a got=%h want=44332211", if4.out_data); end
        @(negedge clk);
        total++; if (if4.out_data !== 32'h44332211 || if4.out_valid !== 1'b1) begin
            bad++; $display("FAIL bp_hold_a_stable got=%h/%b want=44332211/1", if4.out_data, if4.out_valid); end
        if4.out_ready = 1'b1;
        @(negedge clk);
        total++; if (if4.out_data !== 32'h11223344 || if4.out_valid !== 1'b1) begin
            bad++; $display("FAIL bp_then_b got=%h/%b want=11223344/1", if4.out_data, if4.out_valid); end
        total++; if (if4.in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_restored got=%b want=1", if4.in_ready); end
        @(negedge clk);
        total++; if (if4.out_valid !== 1'b0) begin bad++; $display("FAIL bp_drained got=%b want=0", if4.out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] q [$];
        logic [31:0] prev = '0;
        logic        stalled = 1'b0;
        int          sent = 0;
        int          mode;
        int          rot;
        for (int c = 0; c < 400 && (sent < 16 || q.size() != 0); c++) begin
            total++; if (if4.in_ready !== (q.size() < 2)) begin
                bad++; $display("FAIL b2b_in_ready cyc=%0d got=%b want=%b", c, if4.in_ready, q.size() < 2); end
            total++; if (if4.out_valid !== (q.size() != 0)) begin
                bad++; $display("FAIL b2b_out_valid cyc=%0d got=%b want=%b", c, if4.out_valid, q.size() != 0); end
            if (stalled) begin
                total++; if (if4.out_data !== prev) begin
                    bad++; $display("FAIL b2b_stall_hold cyc=%0d got=%h want=%h", c, if4.out_data, prev); end
            end
            if4.out_ready = (sent >= 16) ? 1'b1 : 1'($urandom_range(0, 1));
            if4.in_valid  = (sent < 16) && ($urandom_range(0, 3) != 0);
            mode = int'($urandom_range(0, 3));
            rot  = int'($urandom_range(0, 3));
            if4.in_data = $urandom;
            if4.in_mode = 2'(mode);
            if4.in_rot  = 2'(rot);
            if (if4.out_valid && if4.out_ready && q.size() != 0) begin
                total++; if (if4.out_data !== q[0]) begin
                    bad++; $display("FAIL b2b_data cyc=%0d got=%h want=%h", c, if4.out_data, q[0]); end
                void'(q.pop_front());
            end
            if (if4.in_valid && if4.in_ready) begin
                q.push_back(ref_perm(if4.in_data, mode, rot, 4));
                sent++;
            end
            stalled = if4.out_valid && !if4.out_ready;
            prev = if4.out_data;
            @(negedge clk);
        end
        if4.in_valid = 1'b0;
        total++; if (sent != 16 || q.size() != 0) begin
            bad++; $display("FAIL b2b_timeout sent=%0d pending=%0d want=16/0", sent, q.size()); end
        total++; if (if4.out_valid !== 1'b0) begin bad++; $display("FAIL b2b_extra_beat got=%b want=0", if4.out_valid); end
    endtask

    task automatic test_reset_full();
        int leaked = 0;
        if4.out_ready = 1'b0;
        if4.in_valid = 1'b1; if4.in_data = 32'h44332211; if4.in_mode = 2'd0;
        @(negedge clk);
        if4.in_data = 32'haabbccdd; if4.in_mode = 2'd3;
        @(negedge clk);
        if4.in_valid = 1'b0;
        total++; if (if4.in_ready !== 1'b0 || if4.out_valid !== 1'b1) begin
            bad++; $display("FAIL rf_full got=%b/%b want=0/1", if4.in_ready, if4.out_valid); end
        rst_n = 1'b0;
        @(negedge clk);
        total++; if (if4.out_valid !== 1'b0) begin bad++; $display("FAIL rf_out_valid got=%b want=0", if4.out_valid); end
        total++; if (if4.out_data !== 32'h0) begin bad++; $display("FAIL rf_out_data got=%h want=0", if4.out_data); end
        total++; if (if4.in_ready !== 1'b1) begin bad++; $display("FAIL rf_in_ready got=%b want=1", if4.in_ready); end
        rst_n = 1'b1;
        if4.out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (if4.out_valid !== 1'b0) leaked++;
        end
        total++; if (leaked != 0) begin bad++; $display("FAIL rf_held_beats_emitted got=%0d want=0", leaked); end
    endtask

    task automatic test_odd_lanes();
        logic [1:0]  modes [4] = '{2'd1, 2'd3, 2'd2, 2'd2};
        logic [1:0]  rots  [4] = '{2'd0, 2'd0, 2'd2, 2'd3};
        logic [23:0] exps  [4] = '{24'h331122, 24'h112233, 24'h221133, 24'h332211};
        logic [31:0] model;
        for (int t = 0; t < 4; t++) begin
            if3.in_valid = 1'b1; if3.in_data = 24'h332211;
            if3.in_mode = modes[t]; if3.in_rot = rots[t];
            model = ref_perm(32'h00332211, int'(modes[t]), int'(rots[t]), 3);
            @(negedge clk);
            if3.in_valid = 1'b0;
            total++; if (if3.out_valid !== 1'b1 || if3.out_data !== exps[t]) begin
                bad++; $display("FAIL odd_mode%0d case=%0d got=%h/%b want=%h/1", modes[t], t, if3.out_data, if3.out_valid, exps[t]); end
            total++; if (if3.out_data !== model[23:0]) begin
                bad++; $display("FAIL odd_model case=%0d got=%h want=%h", t, if3.out_data, model[23:0]); end
            @(negedge clk);
        end
    endtask

    initial begin
        if4.in_valid = 1'b0; if4.in_data = '0; if4.in_mode = '0; if4.in_rot = '0; if4.out_ready = 1'b1;
        if3.in_valid = 1'b0; if3.in_data = '0; if3.in_mode = '0; if3.in_rot = '0; if3.out_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_pass_idle();
        test_modes();
        test_backpressure();
        test_back_to_back();
        test_reset_full();
        test_odd_lanes();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/data_permuter_pipe.md
Name: data_permuter_pipe

Overview:
- Registered, handshaked, multi-channel generalisation of the two-input data swapper.
- Accepts NUM_CH lanes of WIDTH bits packed on one bus. Permutes them per a per-beat mode: pass, pairwise swap, rotate or reverse.
- Drives the result through a 2-entry skid buffer with valid/ready on both sides.
- Sits between a lane-ordered producer and a consumer that needs lanes reordered, without stalling throughput.

Parameters:
- WIDTH, 8, bits per lane (>=1).
- NUM_CH, 4, number of lanes (>=2).
- ROT_W, $clog2(NUM_CH) (min 1), width of rotate amount.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat.
- in_data  input  NUM_CH*WIDTH  packed lanes; lane i = in_data[i*WIDTH +: WIDTH].
- in_mode  input  2  permutation mode, sampled with the beat.
- in_rot  input  ROT_W  rotate amount, sampled with the beat.
- out_valid  output  1  output beat valid.
- out_ready  input  1  consumer accepts output.
- out_data  output  NUM_CH*WIDTH  permuted lanes, same packing.

Behaviour:
- Synchronous active-low reset, single clock domain.
- Reset, while rst_n=0 at a clk edge:
  - out_valid=0, out_data=0, skid entry invalid and data 0.
  - in_ready=1 immediately after reset.
  - Beats presented during reset are dropped.
  - Reset mid-transfer discards any held beats.
- Modes (lane i of output = o[i], input lane = x[j]):
  - 0 PASS: o[i]=x[i].
  - 1 SWAP_PAIRS: o[2k]=x[2k+1], o[2k+1]=x[2k]. If NUM_CH is odd, the last lane passes through.
  - 2 ROTATE: o[i]=x[(i+r) mod NUM_CH], with r = in_rot mod NUM_CH. r=0 behaves as PASS.
  - 3 REVERSE: o[i]=x[NUM_CH-1-i].
- Handshake:
  - Transfer occurs on in_valid&&in_ready, or out_valid&&out_ready, at a clk edge.
  - in_mode and in_rot are only meaningful with an accepted beat.
  - A permutation is computed combinationally from in_data/in_mode/in_rot. It is captured at accept, never re-evaluated later.
- Latency and throughput:
  - An accepted beat appears on out_data/out_valid in the next cycle if the output register is empty or being drained.
  - Sustained throughput is 1 beat/cycle with out_ready=1.
- Skid buffer:
  - Output register (OR) plus one skid entry (SK).
  - in_ready = !SK_valid, driven from a register with no combinational path from out_ready.
  - On accept:
    - if OR empty, or OR draining this cycle with SK empty → write OR;
    - else → write SK.
  - On OR drain with SK valid → SK moves to OR, SK cleared.
  - Simultaneous drain and accept with SK valid cannot occur (in_ready=0).
- Ordering and stall rules:
  - Strict FIFO order; no beat is dropped or duplicated.
  - While out_valid=1 and out_ready=0, out_data is held stable.
  - Full: OR and SK both valid → in_ready=0. Empty: out_valid=0, out_data holds its last value.
- No X propagation: out_data never changes while out_valid=0 except at reset.

Decomposition:
- Package data_swapper_pkg:
  - enum perm_mode_e {PERM_PASS=0, PERM_SWAP=1, PERM_ROT=2, PERM_REV=3}, 2 bits.
  - Lane index helper function for rotate modulo.
- Sub-module data_permute_core:
  - Purely combinational NUM_CH×WIDTH lane mux, mode+rot → permuted bus.
  - Reused by a future unregistered variant.
  - The top holds only skid/handshake logic.

Test Plan (WIDTH=8, NUM_CH=4, in_data=0x44332211, out_ready=1 unless stated):
- Reset then PASS beat → next cycle out_valid=1, out_data=0x44332211; cycle after with no input → out_valid=0.
- SWAP_PAIRS → 0x33441122. REVERSE → 0x11223344.
- ROTATE in_rot=1 → 0x11443322. in_rot=3 → 0x33221144. in_rot=0 → 0x44332211.
- Backpressure: hold out_ready=0, send beats A=0x44332211(PASS) and B(REVERSE) on consecutive cycles.
  - Expect in_ready=0 after B; out_data=A stable.
  - Raise out_ready → A then B=0x11223344 in order, then in_ready=1.
- Back-to-back 16 beats with random modes and out_ready toggling randomly → scoreboard against a reference model; zero loss, order preserved.
- Reset asserted with both OR and SK full → next cycle out_valid=0, out_data=0, in_ready=1; held beats never emitted.
- NUM_CH=3 instance with SWAP_PAIRS on 0x332211 → 0x331122.
